// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IR_W   = 2 * DATA_W;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic WR_READ   = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory pins plus the instruction valid/ready handshake to decode.
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wr;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_o;
    logic [IR_W-1:0]   ir_out;
    logic              ir_valid;
    logic              ir_ready;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_address,
        output mem_data,
        output mem_wr,
        output mem_cs,
        input  mem_o,
        output ir_out,
        output ir_valid,
        input  ir_ready,
        output pc_out
    );

    modport slave (
        input  mem_address,
        input  mem_data,
        input  mem_wr,
        input  mem_cs,
        output mem_o,
        input  ir_out,
        input  ir_valid,
        output ir_ready,
        input  pc_out
    );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: load, +2 step per instruction, wraps at 2^ADDR_W.
module fetch_pc
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(2);
        end
    end

    assign pc_plus1 = pc + ADDR_W'(1);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads two bytes per instruction from byte-wide memory
// and hands the 16-bit word to decode over valid/ready.
module instruction_fetch
    import fetch_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_load_value,
    instruction_fetch_if.master bus
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [IR_W-1:0]   ir_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              fetching;

    fetch_pc u_pc (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (pc_load),
        .load_value (pc_load_value),
        .inc        (state == FETCH_HI),
        .pc         (pc),
        .pc_plus1   (pc_plus1)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (enable) state_nx = FETCH_LO;
            FETCH_LO: state_nx = FETCH_HI;
            FETCH_HI: state_nx = HOLD;
            HOLD: begin
                if (bus.ir_ready) state_nx = enable ? FETCH_LO : IDLE;
            end
            default:  state_nx = IDLE;
        endcase
        // Redirect overrides everything, including a pending hold.
        if (pc_load) state_nx = enable ? FETCH_LO : IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ir_q     <= '0;
            pc_out_q <= '0;
        end else begin
            state <= state_nx;
            if (!pc_load && state == FETCH_LO) begin
                ir_q[DATA_W-1:0] <= bus.mem_o;
            end
            if (!pc_load && state == FETCH_HI) begin
                ir_q[IR_W-1:DATA_W] <= bus.mem_o;
                pc_out_q            <= pc;
            end
        end
    end

    assign fetching        = (state == FETCH_LO) || (state == FETCH_HI);
    assign bus.mem_cs      = fetching ? CS_ACTIVE : ~CS_ACTIVE;
    assign bus.mem_address = (state == FETCH_HI) ? pc_plus1 : pc;
    assign bus.mem_wr      = WR_READ;
    assign bus.mem_data    = '0;
    assign bus.ir_out      = ir_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.ir_valid    = (state == HOLD);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a combinational memory model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  pc;
    } xfer_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       pc_load;
    logic [7:0] pc_load_value;
    logic [7:0] mem [256];

    int    compared   = 0;
    int    mismatched = 0;
    xfer_t expq [$];
    xfer_t exp_x;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .bus           (bus.master)
    );

    always #5 clock = ~clock;

    assign bus.mem_o = (bus.mem_cs == 1'b0 && bus.mem_wr == 1'b0)
                       ? mem[bus.mem_address] : 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk_fetch(input string name, input logic [7:0] addr);
        check({name, "_cs"}, bus.mem_cs, 0);
        check({name, "_addr"}, bus.mem_address, addr);
        check({name, "_valid"}, bus.ir_valid, 0);
    endtask

    task automatic chk_reset(input string name);
        check({name, "_valid"}, bus.ir_valid, 0);
        check({name, "_cs"}, bus.mem_cs, 1);
        check({name, "_addr"}, bus.mem_address, 0);
        check({name, "_wr"}, bus.mem_wr, 0);
        check({name, "_data"}, bus.mem_data, 0);
        check({name, "_ir"}, bus.ir_out, 0);
        check({name, "_pc"}, bus.pc_out, 0);
    endtask

    // Monitor: every accepted transfer must match the next expected word.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_xfer: got ir %0h pc %0h, expected none",
                         bus.ir_out, bus.pc_out);
            end else begin
                exp_x = expq.pop_front();
                check("xfer_ir", bus.ir_out, exp_x.ir);
                check("xfer_pc", bus.pc_out, exp_x.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78; mem[8'h03] = 8'h56;
        mem[8'hFF] = 8'hCD;
        mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
        mem[8'h80] = 8'h01; mem[8'h81] = 8'h02;

        reset_n       = 1'b0;
        enable        = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 8'h00;
        bus.ir_ready  = 1'b0;
        tick;
        tick;
        chk_reset("reset");

        reset_n = 1'b1;
        enable  = 1'b1;
        expq.push_back('{ir: 16'h1234, pc: 8'h00});
        tick; chk_fetch("basic_lo", 8'h00);
        tick; chk_fetch("basic_hi", 8'h01);
        tick;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.ir_valid, 1);
            check("bp_cs", bus.mem_cs, 1);
            check("bp_ir", bus.ir_out, 16'h1234);
            check("bp_pc", bus.pc_out, 8'h00);
            tick;
        end
        bus.ir_ready = 1'b1;
        expq.push_back('{ir: 16'h5678, pc: 8'h02});
        tick; chk_fetch("next_lo", 8'h02);
        tick; chk_fetch("next_hi", 8'h03);
        tick; check("next_valid", bus.ir_valid, 1);
        tick; chk_fetch("after2_lo", 8'h04);

        mem[8'h00]    = 8'hAB;
        pc_load       = 1'b1;
        pc_load_value = 8'hFF;
        expq.push_back('{ir: 16'hABCD, pc: 8'hFF});
        tick;
        pc_load = 1'b0;
        chk_fetch("wrap_lo", 8'hFF);
        tick; chk_fetch("wrap_hi", 8'h00);
        tick; check("wrap_valid", bus.ir_valid, 1);
        expq.push_back('{ir: 16'h7812, pc: 8'h01});
        tick; chk_fetch("postwrap_lo", 8'h01);
        tick; chk_fetch("postwrap_hi", 8'h02);
        tick; check("postwrap_valid", bus.ir_valid, 1);
        tick; chk_fetch("pre_redir_lo", 8'h03);
        tick; chk_fetch("pre_redir_hi", 8'h04);

        pc_load       = 1'b1;
        pc_load_value = 8'h40;
        expq.push_back('{ir: 16'h2211, pc: 8'h40});
        tick;
        pc_load = 1'b0;
        chk_fetch("redir_lo", 8'h40);
        tick; chk_fetch("redir_hi", 8'h41);
        tick; check("redir_valid", bus.ir_valid, 1);

        pc_load       = 1'b1;
        pc_load_value = 8'h80;
        expq.push_back('{ir: 16'h0201, pc: 8'h80});
        tick;
        pc_load = 1'b0;
        chk_fetch("ldacc_lo", 8'h80);

        enable = 1'b0;
        tick; chk_fetch("en_off_hi", 8'h81);
        tick; check("en_off_valid", bus.ir_valid, 1);
        tick;
        check("idle_cs", bus.mem_cs, 1);
        check("idle_valid", bus.ir_valid, 0);
        tick;
        check("idle2_cs", bus.mem_cs, 1);

        enable = 1'b1;
        tick; chk_fetch("rst_lo", 8'h82);
        tick; chk_fetch("rst_hi", 8'h83);
        reset_n = 1'b0;
        #1;
        chk_reset("async_rst");
        check("queue_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage upstream of the byte-wide `Memory` block. Holds the 8-bit program counter, drives `Memory`'s address, chip-select and read/write pins, and assembles two consecutive bytes into a 16-bit instruction word (low byte at PC, high byte at PC+1). The word goes to the decode stage through a valid/ready handshake. A PC redirect port (`pc_load`) supports branches.

## Interface
- `ADDR_W`, 8, memory address width / PC width
- `DATA_W`, 8, memory data width
- `IR_W`, 16, instruction width (= 2·DATA_W)

- `clock`  in  1  system clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  fetching permitted
- `pc_load`  in  1  redirect PC this cycle
- `pc_load_value`  in  ADDR_W  new PC on redirect
- `mem_address`  out  ADDR_W  to `Memory` address
- `mem_data`  out  DATA_W  to `Memory` data; constant 0
- `mem_wr`  out  1  to `Memory` wr; constant 0 (read only)
- `mem_cs`  out  1  to `Memory` cs; active-low
- `mem_o`  in  DATA_W  from `Memory` output
- `ir_out`  out  IR_W  assembled instruction
- `ir_valid`  out  1  `ir_out` holds a complete instruction
- `ir_ready`  in  1  decode stage accepts `ir_out`
- `pc_out`  out  ADDR_W  address of the instruction in `ir_out`

## Operation
- States:
  - IDLE: `mem_cs`=1.
  - FETCH_LO: `mem_cs`=0, `mem_address`=PC.
  - FETCH_HI: `mem_cs`=0, `mem_address`=PC+1 mod 256.
  - HOLD: `ir_valid`=1, `mem_cs`=1.
- Memory contract:
  - Reads are combinational: `mem_o` = mem[`mem_address`] in the same cycle while `mem_cs`=0 and `mem_wr`=0.
  - Writes by `Memory` are never issued by this block.
- Transitions:
  - IDLE→FETCH_LO when `enable`=1.
  - FETCH_LO→FETCH_HI unconditionally; the edge captures `mem_o` into `ir_out[7:0]`.
  - FETCH_HI→HOLD; the edge captures `mem_o` into `ir_out[15:8]`, copies PC to `pc_out`, and sets PC ← PC+2 mod 256.
  - HOLD with `ir_ready`=1 → FETCH_LO if `enable`=1, else IDLE.
  - HOLD with `ir_ready`=0 → stay; `ir_out`, `pc_out` and `ir_valid` are stable.
- `enable` is sampled only in IDLE and on HOLD exit. Deasserting it mid-fetch does not abort the fetch in progress.
- `pc_load`=1 (any state, highest priority):
  - PC ← `pc_load_value`; any partial fetch is discarded.
  - `ir_valid` goes low on the next edge.
  - Next state is FETCH_LO if `enable`=1, else IDLE.
  - If `ir_valid` and `ir_ready` are both 1 in the same cycle, that transfer counts as accepted.
- PC arithmetic is modulo 2^ADDR_W:
  - PC=255: FETCH_LO reads 255, FETCH_HI reads 0, new PC=1.
  - PC=254: new PC=0.

## Timing
- Reset values: state=IDLE, PC=0, `ir_out`=0, `pc_out`=0, `ir_valid`=0, `mem_cs`=1, `mem_address`=0, `mem_wr`=0, `mem_data`=0.
- Reset is asynchronous on assert; reset mid-fetch drops to IDLE immediately with no partial data kept.
- Outputs are decoded from registered state and PC only. No combinational path from `ir_ready` or `pc_load` to any output.
- Latency: `enable` high in IDLE at edge N → `ir_valid`=1 after edge N+3 (FETCH_LO at N+1, FETCH_HI at N+2, HOLD at N+3).
- Sustained throughput with `ir_ready` held at 1: one instruction per 3 cycles.
- `pc_load` at edge N → FETCH_LO with the new address at N+1.

## Structure
- Shared package `fetch_pkg` contains:
  - state enum {IDLE, FETCH_LO, FETCH_HI, HOLD};
  - constants ADDR_W, DATA_W, IR_W;
  - `CS_ACTIVE`=0, `WR_READ`=0.
- One sub-module, `fetch_pc`: PC register with load, +2 increment and wrap, exposing PC and PC+1.
- FSM, IR byte capture and memory pin drive stay in `instruction_fetch`.

## Test plan
- Reset and basic fetch:
  - Stimulus: memory preloaded mem[0]=0x34, mem[1]=0x12; `enable`=1, `ir_ready`=1.
  - Required: `mem_cs`=0 on cycles 1–2 with addresses 0 then 1; `ir_valid` after edge 3; `ir_out`=0x1234, `pc_out`=0; next fetch at address 2.
- Backpressure:
  - Stimulus: `ir_ready`=0 for 5 cycles in HOLD.
  - Required: `ir_out`/`pc_out` unchanged, `mem_cs`=1 throughout; `ir_ready`=1 → FETCH_LO at address 2 on the next cycle.
- Wrap-around:
  - Stimulus: `pc_load_value`=255; mem[255]=0xCD, mem[0]=0xAB.
  - Required: addresses 255 then 0; `ir_out`=0xABCD, `pc_out`=255; next fetch at address 1.
- Redirect mid-fetch:
  - Stimulus: `pc_load`=1, value 0x40, asserted during FETCH_HI.
  - Required: partial word discarded, no `ir_valid` pulse; next address 0x40.
  - Stimulus: `pc_load` together with `ir_valid` and `ir_ready` all 1 in one cycle.
  - Required: transfer counted as accepted; next fetch at the new PC.
- Enable and reset:
  - `enable`=0 during FETCH_LO: fetch completes to HOLD, then IDLE after accept.
  - `reset_n` low mid-FETCH_HI: all outputs at reset values before the next clock edge.
